bcd_time_keeper: RTL and testbench
==================================

Name: bcd_time_keeper

Overview:
- Upstream timekeeping stage for the VGA clock display.
- Holds current time as six BCD digits (hh:mm:ss, 24-hour) and advances it once per second from the system clock.
- Provides a set-time mode in which the user freezes the clock and increments hours, minutes or seconds with button pulses.
- Drives the digit inputs and the settime flag of the display renderer directly.

Parameters:
- TICK_DIV, 100_000_000, system clock cycles per one-second tick (100 MHz board clock); bench uses 4.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- set_toggle  in  1  single-cycle pulse (debounced upstream); toggles RUN/SET mode
- field_next  in  1  single-cycle pulse; in SET mode, advances selected field hour->min->sec->hour
- inc  in  1  single-cycle pulse; in SET mode, increments selected field
- settime  out  1  1 while in SET mode
- sel_field  out  2  selected field: 0=sec, 1=min, 2=hour; 3 never driven
- secMSB, secLSB, minMSB, minLSB, hourMSB, hourLSB  out  4 each  BCD time digits
- sec_tick  out  1  one-cycle pulse when a one-second tick advances time (RUN only)

Behaviour:
- All state is updated on the rising edge of clk.
- Reset values: time 00:00:00, settime=0 (RUN), sel_field=2, prescaler=0, sec_tick=0.
- Reset asserted mid-count or mid-SET wins over every other input.
- Prescaler: width $clog2(TICK_DIV).
  - In RUN it counts 0..TICK_DIV-1.
  - The cycle on which it equals TICK_DIV-1 is a tick; it then wraps to 0.
  - In SET it is held at 0.
  - After leaving SET, the first tick occurs exactly TICK_DIV cycles later.
- Outputs (time, settime, sel_field) are registered. sec_tick is registered and asserts on the cycle after the tick, aligned with the updated time.
- The first tick after reset therefore produces 00:00:01 on cycle TICK_DIV+1 after reset deasserts.
- RUN tick carry chain: secLSB 9->0 carries into secMSB; secMSB 5->0 carries into minutes; minutes carry the same way into hours.
- Hours wrap 23->00; full wrap 23:59:59 -> 00:00:00.
- Digit values are never outside 0-9 (MSB of sec/min 0-5; hourMSB 0-2).
- Mode state machine, two states: RUN and SET.
  - RUN + set_toggle -> SET. sel_field is forced to 2 and the tick coinciding with the toggle cycle is discarded (time unchanged).
  - SET + set_toggle -> RUN. Prescaler restarts from 0.
- SET mode: time is frozen.
  - inc increments only the selected field, wrapping without carry: sec 59->00, min 59->00, hour 23->00.
  - field_next cycles sel_field 2->1->0->2.
- Simultaneous inputs:
  - set_toggle has priority; inc and field_next in the same cycle are ignored.
  - inc and field_next together: inc applies to the current field, and the selection then advances.
- field_next and inc are ignored in RUN; sel_field holds its value in RUN.
- Held (multi-cycle) inputs are counted once per cycle; pulse shaping is upstream's responsibility.

Decomposition:
- Shared package holds:
  - field encodings FIELD_SEC=0, FIELD_MIN=1, FIELD_HOUR=2
  - limits SEC_MAX=59, MIN_MAX=59, HOUR_MAX=23, as BCD MSB/LSB pairs
  - mode encoding RUN=0, SET=1
- Sub-module bcd_mod_counter, instantiated three times:
  - two BCD digits, parameterised by max MSB/LSB
  - inputs clk, reset, en, carry_in
  - outputs msb, lsb, carry_out (asserted when at max and carry_in=1)
- Top level: prescaler, mode FSM, field select, and the mux of the carry_in sources (tick chain vs. SET inc).

Test Plan (TICK_DIV=4):
- Reset, run 4 cycles -> time 00:00:01 with sec_tick pulse; after 40 more cycles -> 00:00:11, digits secMSB=1, secLSB=1.
- Preload via SET to 23:59:59, set_toggle back to RUN, wait 4 cycles -> 00:00:00, sec_tick=1.
- RUN at 12:34:56, set_toggle -> settime=1, sel_field=2; 20 idle cycles -> time stays 12:34:56, no sec_tick.
- SET: 13 inc pulses on hour from 12 -> 01 (wrapped past 23); field_next, 6 inc on min from 34 -> 40; field_next, inc from sec 59 -> 00 with min unchanged.
- Same cycle set_toggle+inc in SET -> RUN entered, selected field unchanged; same cycle tick+set_toggle in RUN -> SET, time unchanged.
- Reset asserted while in SET at 05:06:07 -> next cycle 00:00:00, settime=0, sel_field=2.

Source files
------------

// File: rtl/bcd_time_keeper_pkg.sv
// Shared definitions for the BCD time keeper: mode and field encodings,
// per-field BCD limits, and the field-select rotation helper.
package bcd_time_keeper_pkg;

  typedef enum logic {
    RUN = 1'b0,
    SET = 1'b1
  } mode_e;

  localparam logic [1:0] FIELD_SEC  = 2'd0;
  localparam logic [1:0] FIELD_MIN  = 2'd1;
  localparam logic [1:0] FIELD_HOUR = 2'd2;

  localparam logic [3:0] SEC_MAX_MSB  = 4'd5;
  localparam logic [3:0] SEC_MAX_LSB  = 4'd9;
  localparam logic [3:0] MIN_MAX_MSB  = 4'd5;
  localparam logic [3:0] MIN_MAX_LSB  = 4'd9;
  localparam logic [3:0] HOUR_MAX_MSB = 4'd2;
  localparam logic [3:0] HOUR_MAX_LSB = 4'd3;

  // Selection rotates hour -> min -> sec -> hour; the unused code 3 recovers to hour.
  function automatic logic [1:0] next_field(input logic [1:0] f);
    case (f)
      FIELD_HOUR: next_field = FIELD_MIN;
      FIELD_MIN:  next_field = FIELD_SEC;
      default:    next_field = FIELD_HOUR;
    endcase
  endfunction

endpackage

// File: rtl/bcd_time_keeper_if.sv
// Button/display bus of the time keeper.
//   master: drives the button pulses, observes mode, field select and digits
//   slave : the time keeper itself
interface bcd_time_keeper_if;

  logic       set_toggle;
  logic       field_next;
  logic       inc;
  logic       settime;
  logic [1:0] sel_field;
  logic [3:0] secMSB;
  logic [3:0] secLSB;
  logic [3:0] minMSB;
  logic [3:0] minLSB;
  logic [3:0] hourMSB;
  logic [3:0] hourLSB;
  logic       sec_tick;

  modport master (
    output set_toggle, field_next, inc,
    input  settime, sel_field, secMSB, secLSB, minMSB, minLSB,
           hourMSB, hourLSB, sec_tick
  );

  modport slave (
    input  set_toggle, field_next, inc,
    output settime, sel_field, secMSB, secLSB, minMSB, minLSB,
           hourMSB, hourLSB, sec_tick
  );

endinterface

// File: rtl/bcd_time_keeper_bcd_mod_counter.sv
// Two-digit BCD modulo counter, wrapping from MAX_MSB:MAX_LSB to 00.
//   clk, reset : clock, synchronous active-high reset
//   en         : gates any update this cycle
//   carry_in   : increment request
//   msb, lsb   : registered BCD digits
//   carry_out  : at maximum while an increment is requested
module bcd_mod_counter #(
  parameter logic [3:0] MAX_MSB = 4'd5,
  parameter logic [3:0] MAX_LSB = 4'd9
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       carry_in,
  output logic [3:0] msb,
  output logic [3:0] lsb,
  output logic       carry_out
);

  logic at_max;

  assign at_max    = (msb == MAX_MSB) && (lsb == MAX_LSB);
  assign carry_out = at_max && carry_in;

  // Digit update: wrap at the field maximum, otherwise ordinary BCD increment.
  always_ff @(posedge clk) begin
    if (reset) begin
      msb <= 4'd0;
      lsb <= 4'd0;
    end else if (en && carry_in) begin
      if (at_max) begin
        msb <= 4'd0;
        lsb <= 4'd0;
      end else if (lsb == 4'd9) begin
        msb <= msb + 4'd1;
        lsb <= 4'd0;
      end else begin
        lsb <= lsb + 4'd1;
      end
    end
  end

endmodule

// File: rtl/bcd_time_keeper.sv
// 24-hour hh:mm:ss BCD time keeper with a freeze-and-edit SET mode.
//   clk, reset : system clock, synchronous active-high reset
//   bus        : button pulses in; settime, sel_field, six BCD digits and
//                the one-second sec_tick pulse out (all registered)
module bcd_time_keeper
  import bcd_time_keeper_pkg::*;
#(
  parameter int unsigned TICK_DIV = 100_000_000
) (
  input  logic               clk,
  input  logic               reset,
  bcd_time_keeper_if.slave   bus
);

  localparam int unsigned PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  mode_e              mode;
  logic [1:0]         sel;
  logic [PRESC_W-1:0] presc;
  logic               sec_tick_q;

  logic tick_c;
  logic run_c;
  logic cnt_en_c;
  logic sec_cin_c, min_cin_c, hour_cin_c;
  logic sec_co_c, min_co_c;
  logic hour_carry_unused;

  logic [3:0] sec_msb, sec_lsb, min_msb, min_lsb, hour_msb, hour_lsb;

  assign run_c  = (mode == RUN);
  assign tick_c = run_c && (presc == PRESC_W'(TICK_DIV - 1));

  // A set_toggle cycle freezes the digits: it discards a coinciding tick in
  // RUN and an inc in SET.
  assign cnt_en_c = !bus.set_toggle;

  // Increment sources: tick ripple chain in RUN, per-field inc (no carry) in SET.
  assign sec_cin_c  = run_c ? tick_c   : (bus.inc && (sel == FIELD_SEC));
  assign min_cin_c  = run_c ? sec_co_c : (bus.inc && (sel == FIELD_MIN));
  assign hour_cin_c = run_c ? min_co_c : (bus.inc && (sel == FIELD_HOUR));

  // Mode FSM, prescaler, field select and tick pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      mode       <= RUN;
      sel        <= FIELD_HOUR;
      presc      <= '0;
      sec_tick_q <= 1'b0;
    end else begin
      sec_tick_q <= tick_c && !bus.set_toggle;
      case (mode)
        RUN: begin
          if (bus.set_toggle) begin
            mode  <= SET;
            sel   <= FIELD_HOUR;
            presc <= '0;
          end else if (tick_c) begin
            presc <= '0;
          end else begin
            presc <= presc + PRESC_W'(1);
          end
        end
        SET: begin
          presc <= '0;
          if (bus.set_toggle) begin
            mode <= RUN;
          end else if (bus.field_next) begin
            sel <= next_field(sel);
          end
        end
        default: mode <= RUN;
      endcase
    end
  end

  bcd_mod_counter #(.MAX_MSB(SEC_MAX_MSB), .MAX_LSB(SEC_MAX_LSB)) u_sec (
    .clk       (clk),
    .reset     (reset),
    .en        (cnt_en_c),
    .carry_in  (sec_cin_c),
    .msb       (sec_msb),
    .lsb       (sec_lsb),
    .carry_out (sec_co_c)
  );

  bcd_mod_counter #(.MAX_MSB(MIN_MAX_MSB), .MAX_LSB(MIN_MAX_LSB)) u_min (
    .clk       (clk),
    .reset     (reset),
    .en        (cnt_en_c),
    .carry_in  (min_cin_c),
    .msb       (min_msb),
    .lsb       (min_lsb),
    .carry_out (min_co_c)
  );

  // Day rollover carry has no consumer.
  bcd_mod_counter #(.MAX_MSB(HOUR_MAX_MSB), .MAX_LSB(HOUR_MAX_LSB)) u_hour (
    .clk       (clk),
    .reset     (reset),
    .en        (cnt_en_c),
    .carry_in  (hour_cin_c),
    .msb       (hour_msb),
    .lsb       (hour_lsb),
    .carry_out (hour_carry_unused)
  );

  assign bus.settime   = (mode == SET);
  assign bus.sel_field = sel;
  assign bus.sec_tick  = sec_tick_q;
  assign bus.secMSB    = sec_msb;
  assign bus.secLSB    = sec_lsb;
  assign bus.minMSB    = min_msb;
  assign bus.minLSB    = min_lsb;
  assign bus.hourMSB   = hour_msb;
  assign bus.hourLSB   = hour_lsb;

endmodule

// File: tb/tb_bcd_time_keeper.sv
// Directed bench for bcd_time_keeper with TICK_DIV=4.
module tb_bcd_time_keeper;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  bcd_time_keeper_if bus ();

  bcd_time_keeper #(.TICK_DIV(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] now_time();
    return {8'h00, bus.hourMSB, bus.hourLSB, bus.minMSB, bus.minLSB, bus.secMSB, bus.secLSB};
  endfunction

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One edge with the given buttons asserted.
  task automatic pulse(input logic st, input logic fn, input logic in);
    bus.set_toggle = st;
    bus.field_next = fn;
    bus.inc        = in;
    cycles(1);
    bus.set_toggle = 1'b0;
    bus.field_next = 1'b0;
    bus.inc        = 1'b0;
  endtask

  task automatic incs(input int n);
    for (int i = 0; i < n; i++) pulse(1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    int seen;
    reset          = 1'b1;
    bus.set_toggle = 1'b0;
    bus.field_next = 1'b0;
    bus.inc        = 1'b0;
    cycles(2);
    check("rst_time", now_time(), 32'h000000);
    check("rst_settime", 32'(bus.settime), 32'd0);
    check("rst_sel", 32'(bus.sel_field), 32'd2);
    check("rst_tick", 32'(bus.sec_tick), 32'd0);
    reset = 1'b0;

    // First tick lands on the 4th edge after reset release.
    cycles(3);
    check("pre_tick_time", now_time(), 32'h000000);
    check("pre_tick_pulse", 32'(bus.sec_tick), 32'd0);
    cycles(1);
    check("tick1_time", now_time(), 32'h000001);
    check("tick1_pulse", 32'(bus.sec_tick), 32'd1);
    cycles(1);
    check("tick1_pulse_end", 32'(bus.sec_tick), 32'd0);
    cycles(39);
    check("tick11_time", now_time(), 32'h000011);
    check("tick11_secMSB", 32'(bus.secMSB), 32'd1);
    check("tick11_secLSB", 32'(bus.secLSB), 32'd1);
    check("tick11_pulse", 32'(bus.sec_tick), 32'd1);

    // Preload 23:59:59 through SET mode, then full day wrap.
    pulse(1'b1, 1'b0, 1'b0);
    check("enter_set", 32'(bus.settime), 32'd1);
    check("enter_set_sel", 32'(bus.sel_field), 32'd2);
    incs(23);
    pulse(1'b0, 1'b1, 1'b0);
    incs(59);
    pulse(1'b0, 1'b1, 1'b0);
    incs(48);
    check("preload", now_time(), 32'h235959);
    pulse(1'b1, 1'b0, 1'b0);
    check("leave_set", 32'(bus.settime), 32'd0);
    check("leave_set_sel", 32'(bus.sel_field), 32'd0);
    cycles(3);
    check("wrap_pre", now_time(), 32'h235959);
    cycles(1);
    check("wrap_time", now_time(), 32'h000000);
    check("wrap_pulse", 32'(bus.sec_tick), 32'd1);

    // Load 12:34:56, run briefly, then freeze.
    pulse(1'b1, 1'b0, 1'b0);
    incs(12);
    pulse(1'b0, 1'b1, 1'b0);
    incs(34);
    pulse(1'b0, 1'b1, 1'b0);
    incs(56);
    pulse(1'b1, 1'b0, 1'b0);
    cycles(1);
    pulse(1'b1, 1'b0, 1'b0);
    check("freeze_settime", 32'(bus.settime), 32'd1);
    check("freeze_sel", 32'(bus.sel_field), 32'd2);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      cycles(1);
      if (bus.sec_tick) seen++;
    end
    check("freeze_time", now_time(), 32'h123456);
    check("freeze_no_tick", 32'(seen), 32'd0);

    // Field edits wrap without carry.
    incs(13);
    check("hour_wrap", now_time(), 32'h013456);
    pulse(1'b0, 1'b1, 1'b0);
    check("sel_min", 32'(bus.sel_field), 32'd1);
    incs(6);
    check("min_edit", now_time(), 32'h014056);
    pulse(1'b0, 1'b1, 1'b0);
    check("sel_sec", 32'(bus.sel_field), 32'd0);
    incs(3);
    check("sec_59", now_time(), 32'h014059);
    incs(1);
    check("sec_wrap", now_time(), 32'h014000);
    pulse(1'b0, 1'b1, 1'b1);
    check("inc_fn_time", now_time(), 32'h014001);
    check("inc_fn_sel", 32'(bus.sel_field), 32'd2);

    // set_toggle beats inc; then a tick coinciding with set_toggle is dropped.
    pulse(1'b1, 1'b0, 1'b1);
    check("st_inc_mode", 32'(bus.settime), 32'd0);
    check("st_inc_time", now_time(), 32'h014001);
    check("st_inc_sel", 32'(bus.sel_field), 32'd2);
    cycles(3);
    check("pre_drop", now_time(), 32'h014001);
    pulse(1'b1, 1'b0, 1'b0);
    check("drop_mode", 32'(bus.settime), 32'd1);
    check("drop_time", now_time(), 32'h014001);
    check("drop_pulse", 32'(bus.sec_tick), 32'd0);

    // Reset while editing at 05:06:07.
    incs(4);
    pulse(1'b0, 1'b1, 1'b0);
    incs(26);
    pulse(1'b0, 1'b1, 1'b0);
    incs(6);
    check("load_050607", now_time(), 32'h050607);
    check("load_sel", 32'(bus.sel_field), 32'd0);
    reset = 1'b1;
    pulse(1'b0, 1'b0, 1'b1);
    reset = 1'b0;
    check("set_rst_time", now_time(), 32'h000000);
    check("set_rst_mode", 32'(bus.settime), 32'd0);
    check("set_rst_sel", 32'(bus.sel_field), 32'd2);
    cycles(4);
    check("post_rst_tick", now_time(), 32'h000001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
